// File: rtl/uart_rx_os_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and
// the oversample tick divider calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    BRK_WAIT = 3'd4
  } uart_rx_state_t;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_OS        = 16;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned calc_tick_div(input int unsigned clk_hz,
                                                input int unsigned baud,
                                                input int unsigned os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receiver-to-FIFO/CSR port bundle: byte write port, status pulses and
// the sticky overrun flag with its clear.
interface uart_rx_os_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      fifo_wr_rq;
  logic                      fifo_full;
  logic                      rx_valid;
  logic                      rx_frame_err;
  logic                      overrun;
  logic                      overrun_clr;
  logic                      rx_busy;

  modport master (
    output rx_data, fifo_wr_rq, rx_valid, rx_frame_err, overrun, rx_busy,
    input  fifo_full, overrun_clr
  );

  modport slave (
    input  rx_data, fifo_wr_rq, rx_valid, rx_frame_err, overrun, rx_busy,
    output fifo_full, overrun_clr
  );

endinterface

// File: rtl/uart_rx_os_tick.sv
// Free-running oversample tick generator; one-clock pulse every TICK_DIV clocks.
module uart_os_tick #(
  parameter int unsigned TICK_DIV = 163
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Single-clock oversampling UART receiver: 2-flop synchroniser, 3-sample
// majority per bit, framing/break detection and RX FIFO write with overrun.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 25_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned OS       = UART_OS,
  parameter int unsigned TICK_DIV = calc_tick_div(CLK_HZ, BAUD, OS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               serial_rx,
  uart_rx_os_if.master       bus
);

  localparam int unsigned OSW = $clog2(OS);
  localparam logic [OSW-1:0] IDX_LO   = OSW'(OS / 2 - 1);
  localparam logic [OSW-1:0] IDX_MID  = OSW'(OS / 2);
  localparam logic [OSW-1:0] IDX_HI   = OSW'(OS / 2 + 1);
  localparam logic [OSW-1:0] IDX_LAST = OSW'(OS - 1);
  localparam logic [2:0]     BIT_LAST = 3'(UART_DATA_BITS - 1);

  logic rx_meta, rx_s;
  logic tick;

  uart_rx_state_t            state;
  logic [OSW-1:0]            os_cnt;
  logic [OSW-1:0]            os_nxt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      smp_a, smp_b;
  logic                      bit_v;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_frame_err;
  logic                      overrun;

  uart_os_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= serial_rx;
      rx_s    <= rx_meta;
    end
  end

  // os_cnt holds the index of the sample taken on the most recent tick.
  always_comb begin
    os_nxt = (os_cnt == IDX_LAST) ? '0 : os_cnt + 1'b1;
    bit_v  = maj3(smp_a, smp_b, rx_s);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      os_cnt       <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      smp_a        <= 1'b1;
      smp_b        <= 1'b1;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state  <= START;
              os_cnt <= '0;
            end
          end
          BRK_WAIT: begin
            if (rx_s) state <= IDLE;
          end
          default: begin
            os_cnt <= os_nxt;
            if (os_nxt == IDX_LO)  smp_a <= rx_s;
            if (os_nxt == IDX_MID) smp_b <= rx_s;
            // Resolve and end-of-bit never coincide since OS >= 8.
            if (os_nxt == IDX_HI) begin
              case (state)
                START: if (bit_v) state <= IDLE;
                DATA:  shift <= {bit_v, shift[UART_DATA_BITS-1:1]};
                STOP: begin
                  if (bit_v) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                    state    <= IDLE;
                  end else begin
                    rx_frame_err <= 1'b1;
                    state        <= BRK_WAIT;
                  end
                end
                default: ;
              endcase
            end
            if (os_cnt == IDX_LAST) begin
              case (state)
                START: begin
                  state   <= DATA;
                  bit_idx <= '0;
                end
                DATA: begin
                  if (bit_idx == BIT_LAST) state <= STOP;
                  else                     bit_idx <= bit_idx + 1'b1;
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (rx_valid && bus.fifo_full) begin
      overrun <= 1'b1;
    end else if (bus.overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  assign bus.rx_data      = rx_data;
  assign bus.rx_valid     = rx_valid;
  assign bus.fifo_wr_rq   = rx_valid & ~bus.fifo_full;
  assign bus.rx_frame_err = rx_frame_err;
  assign bus.overrun      = overrun;
  assign bus.rx_busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: stimulus pushes expected bytes/frame errors,
// a negedge monitor pops and compares whenever the receiver emits.
module tb_uart_rx_os;
  import uart_pkg::*;

  // 25 MHz / (156250 * 16) = 10 clocks per tick, 160 clocks per bit.
  localparam int unsigned BIT = 160;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic serial_rx = 1'b1;

  uart_rx_os_if bus ();

  uart_rx_os #(
    .CLK_HZ(25_000_000),
    .BAUD  (156_250),
    .OS    (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .serial_rx(serial_rx),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    bit         wr;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_good = 8'h00;
  logic       wr_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic exp_good(input logic [7:0] d);
    exp_t e;
    e.ferr = 1'b0;
    e.data = d;
    e.wr   = ~bus.fifo_full;
    q.push_back(e);
    last_good = d;
  endtask

  task automatic exp_ferr();
    exp_t e;
    e.ferr = 1'b1;
    e.data = last_good;
    e.wr   = 1'b0;
    q.push_back(e);
  endtask

  task automatic idle(input int unsigned nbits);
    serial_rx = 1'b1;
    repeat (nbits * BIT) @(posedge clock);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input int unsigned bclk);
    serial_rx = 1'b0;
    repeat (bclk) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      serial_rx = d[i];
      repeat (bclk) @(posedge clock);
    end
    serial_rx = stop;
    repeat (bclk) @(posedge clock);
    serial_rx = 1'b1;
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (bus.rx_valid || bus.rx_frame_err) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output valid=%0b ferr=%0b data=%0h required=none",
                   bus.rx_valid, bus.rx_frame_err, bus.rx_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rx_frame_err", 32'(bus.rx_frame_err), 32'(e.ferr));
          chk("rx_valid", 32'(bus.rx_valid), 32'(!e.ferr));
          chk("rx_data", 32'(bus.rx_data), 32'(e.data));
          chk("fifo_wr_rq", 32'(bus.fifo_wr_rq), 32'(e.wr));
        end
      end
      if (bus.fifo_wr_rq) chk("wr_single_pulse", 32'(wr_prev), 32'd0);
      wr_prev = bus.fifo_wr_rq;
    end
  end

  initial begin
    #(2_000_000 * 10);
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    bus.fifo_full   = 1'b0;
    bus.overrun_clr = 1'b0;
    repeat (5) @(negedge clock);
    chk("rst_rx_data", 32'(bus.rx_data), 32'h00);
    chk("rst_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_wr", 32'(bus.fifo_wr_rq), 32'd0);
    chk("rst_ferr", 32'(bus.rx_frame_err), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    chk("rst_busy", 32'(bus.rx_busy), 32'd0);
    @(posedge clock);
    reset = 1'b1;
    idle(1);

    // Plain bytes, good stop bit.
    exp_good(8'h55); send_byte(8'h55, 1'b1, BIT);
    exp_good(8'h00); send_byte(8'h00, 1'b1, BIT);
    exp_good(8'hA5); send_byte(8'hA5, 1'b1, BIT);
    exp_good(8'hFF); send_byte(8'hFF, 1'b1, BIT);
    idle(1);

    // Three-tick glitch is a false start.
    serial_rx = 1'b0;
    repeat (30) @(posedge clock);
    serial_rx = 1'b1;
    @(negedge clock);
    chk("glitch_busy_high", 32'(bus.rx_busy), 32'd1);
    repeat (BIT - 30) @(negedge clock);
    chk("glitch_busy_low", 32'(bus.rx_busy), 32'd0);
    idle(1);

    // Bad stop bit, data holds 0xFF; then recover.
    exp_ferr(); send_byte(8'hA5, 1'b0, BIT);
    idle(1);
    exp_good(8'h3C); send_byte(8'h3C, 1'b1, BIT);
    idle(1);

    // Long break: one frame error only.
    exp_ferr();
    serial_rx = 1'b0;
    repeat (20 * BIT) @(posedge clock);
    idle(1);
    exp_good(8'h81); send_byte(8'h81, 1'b1, BIT);
    idle(1);

    // Overrun set, clear, and set-wins-over-clear.
    bus.fifo_full = 1'b1;
    exp_good(8'h42); send_byte(8'h42, 1'b1, BIT);
    @(negedge clock);
    chk("overrun_set", 32'(bus.overrun), 32'd1);
    bus.overrun_clr = 1'b1;
    @(negedge clock);
    bus.overrun_clr = 1'b0;
    chk("overrun_clr", 32'(bus.overrun), 32'd0);
    exp_good(8'h99);
    fork
      send_byte(8'h99, 1'b1, BIT);
      begin
        int n;
        n = 0;
        while (bus.rx_valid !== 1'b1 && n < 12 * BIT) begin
          @(negedge clock);
          n++;
        end
        if (n >= 12 * BIT) begin
          checks++;
          errors++;
          $display("FAIL clr_watch actual=timeout required=rx_valid");
        end else begin
          bus.overrun_clr = 1'b1;
          @(negedge clock);
          bus.overrun_clr = 1'b0;
        end
      end
    join
    @(negedge clock);
    chk("overrun_set_wins", 32'(bus.overrun), 32'd1);
    bus.fifo_full = 1'b0;
    idle(1);

    // Reset in the middle of bit 4 of 0xC3.
    serial_rx = 1'b0;
    repeat (BIT) @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      serial_rx = 1'(8'hC3 >> i);
      repeat (BIT) @(posedge clock);
    end
    serial_rx = 1'b0;
    repeat (BIT / 2) @(posedge clock);
    @(negedge clock);
    chk("busy_mid_frame", 32'(bus.rx_busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst2_rx_data", 32'(bus.rx_data), 32'h00);
    chk("rst2_overrun", 32'(bus.overrun), 32'd0);
    chk("rst2_busy", 32'(bus.rx_busy), 32'd0);
    chk("rst2_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst2_wr", 32'(bus.fifo_wr_rq), 32'd0);
    serial_rx = 1'b1;
    repeat (20) @(posedge clock);
    reset = 1'b1;
    last_good = 8'h00;
    idle(1);
    exp_good(8'h7E); send_byte(8'h7E, 1'b1, BIT);
    idle(1);

    // Back-to-back frames with +/-2% baud offset.
    exp_good(8'h5A); send_byte(8'h5A, 1'b1, 163);
    exp_good(8'hA3); send_byte(8'hA3, 1'b1, 157);
    exp_good(8'h69); send_byte(8'h69, 1'b1, 163);
    exp_good(8'hC6); send_byte(8'hC6, 1'b1, 157);

    for (int n = 0; n < 4 * BIT && q.size() != 0; n++) @(negedge clock);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_output actual=none required=ferr%0b_data%0h", e.ferr, e.data);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
